// File: rtl/exu_pkg.sv
// Shared types and constants for the NPC execute stage: ALU op codes, memory
// size codes, FSM states and the packed layouts of the ADU->EXU and EXU->WBU buses.
package exu_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] ALU_ADD  = 6'b110000;
    localparam logic [5:0] ALU_SUB  = 6'b110001;
    localparam logic [5:0] ALU_SLT  = 6'b000011;
    localparam logic [5:0] ALU_SLTU = 6'b000101;
    localparam logic [5:0] ALU_XOR  = 6'b010110;
    localparam logic [5:0] ALU_OR   = 6'b111110;
    localparam logic [5:0] ALU_AND  = 6'b111000;
    localparam logic [5:0] ALU_SLL  = 6'b100000;
    localparam logic [5:0] ALU_SRL  = 6'b100001;
    localparam logic [5:0] ALU_SRA  = 6'b100011;

    localparam logic [3:0] MEM_B  = 4'b0001;
    localparam logic [3:0] MEM_BU = 4'b0101;
    localparam logic [3:0] MEM_H  = 4'b0011;
    localparam logic [3:0] MEM_HU = 4'b0111;
    localparam logic [3:0] MEM_W  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_REQ  = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_DONE     = 2'd3
    } exu_state_e;

    typedef struct packed {
        logic            excp_flush;
        logic            xret_flush;
        logic            break_signal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic [5:0]      alu_op;
        logic            res_from_mem;
        logic            res_from_csr;
        logic            gr_we;
        logic            csr_we;
        logic [3:0]      mem_re;
        logic [3:0]      mem_we;
        logic [4:0]      rd;
        logic            jmp_flag;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_value;
        logic [XLEN-1:0] store_data;
    } adu_exu_t;

    typedef struct packed {
        logic            excp_flush;
        logic            xret_flush;
        logic            break_signal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            gr_we;
        logic            csr_we;
        logic [11:0]     csr_addr;
        logic [XLEN-1:0] csr_wdata;
        logic            redirect;
        logic [XLEN-1:0] redirect_pc;
    } exu_wbu_t;

    // Widths follow the field lists; the WBU bundle carries all listed fields (151 bits).
    localparam int ADU_EXU_BUS_WIDTH = $bits(adu_exu_t);
    localparam int EXU_WBU_BUS_WIDTH = $bits(exu_wbu_t);

    function automatic logic [3:0] size_mask(input logic [3:0] code);
        logic [3:0] mask;
        case (code)
            MEM_B, MEM_BU: mask = 4'b0001;
            MEM_H, MEM_HU: mask = 4'b0011;
            MEM_W:         mask = 4'b1111;
            default:       mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/exu_if.sv
// Handshake and memory-port bundle of the execute stage. The master modport is
// the EXU side; the slave modport is the surrounding pipeline / memory.
interface exu_if;
    import exu_pkg::*;

    logic                         adu_valid_i;
    logic [ADU_EXU_BUS_WIDTH-1:0] adu_exu_bus_i;
    logic                         exu_ready_o;
    logic                         exu_valid_o;
    logic [EXU_WBU_BUS_WIDTH-1:0] exu_wbu_bus_o;
    logic                         wbu_ready_i;
    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [XLEN-1:0]              mem_addr_o;
    logic [XLEN-1:0]              mem_wdata_o;
    logic [3:0]                   mem_wstrb_o;
    logic                         mem_gnt_i;
    logic                         mem_rvalid_i;
    logic [XLEN-1:0]              mem_rdata_i;

    modport master (
        input  adu_valid_i, adu_exu_bus_i, wbu_ready_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output exu_ready_o, exu_valid_o, exu_wbu_bus_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

    modport slave (
        output adu_valid_i, adu_exu_bus_i, wbu_ready_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  exu_ready_o, exu_valid_o, exu_wbu_bus_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
    );

endinterface

// File: rtl/exu_alu.sv
// Combinational ALU of the execute stage; unknown op codes yield zero.
module exu_alu
    import exu_pkg::*;
(
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [5:0]      alu_op,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt_s;

    assign shamt_s = src2[4:0];

    // Operation decode.
    always_comb begin
        result = {XLEN{1'b0}};
        case (alu_op)
            ALU_ADD:  result = src1 + src2;
            ALU_SUB:  result = src1 - src2;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < src2)};
            ALU_XOR:  result = src1 ^ src2;
            ALU_OR:   result = src1 | src2;
            ALU_AND:  result = src1 & src2;
            ALU_SLL:  result = src1 << shamt_s;
            ALU_SRL:  result = src1 >> shamt_s;
            ALU_SRA:  result = $unsigned($signed(src1) >>> shamt_s);
            default:  result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/exu.sv
// Execute stage: latches one ADU bundle, computes ALU/jump results, runs loads
// and stores over a req/gnt/rvalid port and hands one bundle to the WBU.
module exu
    import exu_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_i,
    exu_if.master bus
);

    exu_state_e      state_r;
    exu_state_e      state_nxt_s;
    adu_exu_t        bundle_r;
    adu_exu_t        adu_in_s;
    exu_wbu_t        wbu_out_s;
    logic [XLEN-1:0] ld_raw_r;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] ld_shift_s;
    logic [XLEN-1:0] ld_ext_s;
    logic [XLEN-1:0] result_s;
    logic [XLEN-1:0] wdata_s;
    logic [3:0]      wstrb_s;
    logic [1:0]      offset_s;
    logic            ready_s;
    logic            accept_s;
    logic            in_is_mem_s;
    logic            ld_capture_s;

    assign adu_in_s     = bus.adu_exu_bus_i;
    assign in_is_mem_s  = (adu_in_s.mem_re != 4'b0000) || (adu_in_s.mem_we != 4'b0000);
    assign ready_s      = (state_r == ST_IDLE) || ((state_r == ST_DONE) && bus.wbu_ready_i);
    assign accept_s     = bus.adu_valid_i && ready_s;
    // Load data may arrive together with the grant.
    assign ld_capture_s = bus.mem_rvalid_i &&
                          (((state_r == ST_MEM_REQ) && bus.mem_gnt_i) || (state_r == ST_MEM_WAIT));

    exu_alu u_alu (
        .src1   (bundle_r.src1),
        .src2   (bundle_r.src2),
        .alu_op (bundle_r.alu_op),
        .result (alu_res_s)
    );

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = in_is_mem_s ? ST_MEM_REQ : ST_DONE;
                else          state_nxt_s = ST_IDLE;
            end
            ST_MEM_REQ: begin
                if (bus.mem_gnt_i) state_nxt_s = bus.mem_rvalid_i ? ST_DONE : ST_MEM_WAIT;
                else               state_nxt_s = ST_MEM_REQ;
            end
            ST_MEM_WAIT: begin
                if (bus.mem_rvalid_i) state_nxt_s = ST_DONE;
                else                  state_nxt_s = ST_MEM_WAIT;
            end
            ST_DONE: begin
                if (accept_s)             state_nxt_s = in_is_mem_s ? ST_MEM_REQ : ST_DONE;
                else if (bus.wbu_ready_i) state_nxt_s = ST_IDLE;
                else                      state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, held bundle and raw load word.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r  <= ST_IDLE;
            bundle_r <= '0;
            ld_raw_r <= {XLEN{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) bundle_r <= adu_in_s;
            if (ld_capture_s) ld_raw_r <= bus.mem_rdata_i;
        end
    end

    // Store lane placement: strobe is the size mask shifted to the byte offset.
    always_comb begin
        offset_s = alu_res_s[1:0];
        if (bundle_r.mem_we != 4'b0000) wstrb_s = size_mask(bundle_r.mem_we) << offset_s;
        else                            wstrb_s = 4'b0000;
        case (bundle_r.mem_we)
            MEM_B:   wdata_s = {4{bundle_r.store_data[7:0]}};
            MEM_H:   wdata_s = {2{bundle_r.store_data[15:0]}};
            default: wdata_s = bundle_r.store_data;
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        ld_shift_s = ld_raw_r >> {offset_s, 3'b000};
        case (bundle_r.mem_re)
            MEM_B:   ld_ext_s = {{24{ld_shift_s[7]}}, ld_shift_s[7:0]};
            MEM_BU:  ld_ext_s = {24'h000000, ld_shift_s[7:0]};
            MEM_H:   ld_ext_s = {{16{ld_shift_s[15]}}, ld_shift_s[15:0]};
            MEM_HU:  ld_ext_s = {16'h0000, ld_shift_s[15:0]};
            default: ld_ext_s = ld_shift_s;
        endcase
    end

    // Result select and WBU bundle assembly.
    always_comb begin
        if (bundle_r.res_from_mem)      result_s = ld_ext_s;
        else if (bundle_r.res_from_csr) result_s = bundle_r.csr_value;
        else if (bundle_r.jmp_flag)     result_s = bundle_r.pc + 32'd4;
        else                            result_s = alu_res_s;

        wbu_out_s.excp_flush   = bundle_r.excp_flush;
        wbu_out_s.xret_flush   = bundle_r.xret_flush;
        wbu_out_s.break_signal = bundle_r.break_signal;
        wbu_out_s.pc           = bundle_r.pc;
        wbu_out_s.result       = result_s;
        wbu_out_s.rd           = bundle_r.rd;
        wbu_out_s.gr_we        = bundle_r.gr_we;
        wbu_out_s.csr_we       = bundle_r.csr_we;
        wbu_out_s.csr_addr     = bundle_r.csr_addr;
        wbu_out_s.csr_wdata    = bundle_r.src1;
        wbu_out_s.redirect     = bundle_r.jmp_flag;
        wbu_out_s.redirect_pc  = {alu_res_s[XLEN-1:1], 1'b0};
    end

    assign bus.exu_ready_o   = ready_s;
    assign bus.exu_valid_o   = (state_r == ST_DONE);
    assign bus.exu_wbu_bus_o = wbu_out_s;
    assign bus.mem_req_o     = (state_r == ST_MEM_REQ);
    assign bus.mem_we_o      = (bundle_r.mem_we != 4'b0000);
    assign bus.mem_addr_o    = alu_res_s;
    assign bus.mem_wdata_o   = wdata_s;
    assign bus.mem_wstrb_o   = wstrb_s;

endmodule
